// File: rtl/jp_pad_emu.sv
// rtl/jp_pad_emu.sv - two NES pads: per-switch sync + debounce feeding CD4021-style serial shift registers
// Optional turbo A/B oscillator is built only when JP_TURBO_EN is defined.
module jp_pad_emu #(
    parameter int DEBOUNCE_W  = 16,
    parameter int TURBO_DIV_W = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] btn1_n,
    input  logic [7:0] btn2_n,
    input  logic [1:0] turbo1_n,
    input  logic [1:0] turbo2_n,
    input  logic       jp_clk,
    input  logic       jp_latch,
    output logic       jp_data1,
    output logic       jp_data2,
    output logic [7:0] pad1_state,
    output logic [7:0] pad2_state
);

`ifdef JP_TURBO_EN
    localparam int NB = 20;
    logic [NB-1:0] raw_n;
    assign raw_n = {turbo2_n, turbo1_n, btn2_n, btn1_n};
`else
    localparam int NB = 16;
    logic [NB-1:0] raw_n;
    assign raw_n = {btn2_n, btn1_n};
    logic unused_turbo;
    assign unused_turbo = ^{turbo1_n, turbo2_n, TURBO_DIV_W[0]};
`endif

    logic [NB-1:0]         sync1_q;
    logic [NB-1:0]         sync2_q;
    logic [NB-1:0]         stable_q;
    logic [NB-1:0]         stable_d;
    logic [DEBOUNCE_W-1:0] cnt_q [NB];
    logic [DEBOUNCE_W-1:0] cnt_d [NB];

    // Counter runs only while the synced level disagrees with the accepted level.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            if (~sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == '1) begin
                    stable_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            stable_q <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= raw_n;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef JP_TURBO_EN
    logic [TURBO_DIV_W-1:0] div_q;
    logic                   turbo_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign turbo_phase = div_q[TURBO_DIV_W-1];
    assign pad1_state  = {stable_q[7:2], stable_q[1:0] | (stable_q[17:16] & {2{turbo_phase}})};
    assign pad2_state  = {stable_q[15:10], stable_q[9:8] | (stable_q[19:18] & {2{turbo_phase}})};
`else
    assign pad1_state = stable_q[7:0];
    assign pad2_state = stable_q[15:8];
`endif

    logic [7:0] sr1_q;
    logic [7:0] sr1_d;
    logic [7:0] sr2_q;
    logic [7:0] sr2_d;
    logic       jp_clk_prev_q;

    // Latch is a transparent load and overrides a coincident shift edge.
    always_comb begin
        sr1_d = sr1_q;
        sr2_d = sr2_q;
        if (jp_latch) begin
            sr1_d = ~pad1_state;
            sr2_d = ~pad2_state;
        end else if (jp_clk && !jp_clk_prev_q) begin
            sr1_d = {1'b1, sr1_q[7:1]};
            sr2_d = {1'b1, sr2_q[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr1_q         <= 8'hFF;
            sr2_q         <= 8'hFF;
            jp_clk_prev_q <= 1'b0;
        end else begin
            sr1_q         <= sr1_d;
            sr2_q         <= sr2_d;
            jp_clk_prev_q <= jp_clk;
        end
    end

    assign jp_data1 = sr1_q[0];
    assign jp_data2 = sr2_q[0];

endmodule

// File: tb/tb_jp_pad_emu.sv
// tb/tb_jp_pad_emu.sv - self-checking bench for jp_pad_emu (DEBOUNCE_W=4, TURBO_DIV_W=4)
module tb_jp_pad_emu;

    localparam int TDW = 4;
`ifdef JP_TURBO_EN
    localparam int NBM = 20;
`else
    localparam int NBM = 16;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] btn1_n;
    logic [7:0] btn2_n;
    logic [1:0] turbo1_n;
    logic [1:0] turbo2_n;
    logic       jp_clk;
    logic       jp_latch;
    logic       jp_data1;
    logic       jp_data2;
    logic [7:0] pad1_state;
    logic [7:0] pad2_state;

    jp_pad_emu #(.DEBOUNCE_W(4), .TURBO_DIV_W(TDW)) dut (
        .clk(clk), .rst(rst), .btn1_n(btn1_n), .btn2_n(btn2_n),
        .turbo1_n(turbo1_n), .turbo2_n(turbo2_n), .jp_clk(jp_clk), .jp_latch(jp_latch),
        .jp_data1(jp_data1), .jp_data2(jp_data2), .pad1_state(pad1_state), .pad2_state(pad2_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a button is accepted once its raw level, seen two cycles late,
    // has disagreed with the accepted level for 16 consecutive cycles.
    bit [NBM-1:0] m_hist [$];
    bit [NBM-1:0] m_stable;
    int           m_tcnt;
    bit [7:0]     m_ld1;
    bit [7:0]     m_ld2;
    int           m_idx1;
    int           m_idx2;
    bit           m_prev;

    function automatic bit [NBM-1:0] raw_pressed();
`ifdef JP_TURBO_EN
        return ~{turbo2_n, turbo1_n, btn2_n, btn1_n};
`else
        return ~{btn2_n, btn1_n};
`endif
    endfunction

    function automatic bit [7:0] m_pad(input int p);
        bit [7:0] s;
`ifdef JP_TURBO_EN
        bit ph;
        ph = ((m_tcnt % (1 << TDW)) >= (1 << (TDW - 1)));
`endif
        s = m_stable[p*8 +: 8];
`ifdef JP_TURBO_EN
        s[1:0] = s[1:0] | (m_stable[16 + p*2 +: 2] & {2{ph}});
`endif
        return s;
    endfunction

    function automatic bit m_data(input bit [7:0] ld, input int idx);
        return (idx < 8) ? ld[idx] : 1'b1;
    endfunction

    task automatic model_step();
        bit [7:0] p1;
        bit [7:0] p2;
        bit       diff;
        if (rst) begin
            m_hist.delete();
            repeat (18) m_hist.push_back('0);
            m_stable = '0;
            m_tcnt   = 0;
            m_idx1   = 8;
            m_idx2   = 8;
            m_ld1    = '1;
            m_ld2    = '1;
            m_prev   = 1'b0;
            return;
        end
        p1 = m_pad(0);
        p2 = m_pad(1);
        if (jp_latch) begin
            m_ld1  = ~p1;
            m_ld2  = ~p2;
            m_idx1 = 0;
            m_idx2 = 0;
        end else if (jp_clk && !m_prev) begin
            if (m_idx1 < 8) m_idx1++;
            if (m_idx2 < 8) m_idx2++;
        end
        m_prev = jp_clk;
        m_hist.push_front(raw_pressed());
        void'(m_hist.pop_back());
        for (int b = 0; b < NBM; b++) begin
            diff = 1'b1;
            for (int j = 2; j < 18; j++) begin
                if (m_hist[j][b] == m_stable[b]) diff = 1'b0;
            end
            if (diff) m_stable[b] = ~m_stable[b];
        end
        m_tcnt = (m_tcnt + 1) % (1 << TDW);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic shift_edge();
        jp_clk = 1'b0;
        tick();
        jp_clk = 1'b1;
        tick();
    endtask

    task automatic read_frame(input logic [7:0] e1, input logic [7:0] e2, input int nbits, input int gap);
        logic [7:0] n1;
        logic [7:0] n2;
        n1 = ~e1;
        n2 = ~e2;
        jp_clk   = 1'b0;
        jp_latch = 1'b1;
        tick();
        jp_latch = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) begin
                jp_clk = 1'b1;
                tick();
                jp_clk = 1'b0;
            end
            chk($sformatf("frame data1 bit%0d", i), 32'(jp_data1), 32'((i < 8) ? n1[i] : 1'b1));
            chk($sformatf("frame data2 bit%0d", i), 32'(jp_data2), 32'((i < 8) ? n2[i] : 1'b1));
            repeat (gap - 1) tick();
        end
    endtask

    typedef struct {
        logic [7:0] b1_n;
        logic [7:0] b2_n;
        logic [7:0] exp1;
        logic [7:0] exp2;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{8'hFE, 8'hFF, 8'h01, 8'h00};
        vecs[1] = '{8'h5A, 8'hC3, 8'hA5, 8'h3C};
        vecs[2] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
        vecs[3] = '{8'hFF, 8'h7F, 8'h00, 8'h80};
        vecs[4] = '{8'hF6, 8'h00, 8'h09, 8'hFF};

        rst = 1'b1; btn1_n = 8'hFF; btn2_n = 8'hFF; turbo1_n = 2'b11; turbo2_n = 2'b11;
        jp_clk = 1'b0; jp_latch = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset pad1_state", 32'(pad1_state), 32'h00);
        chk("reset pad2_state", 32'(pad2_state), 32'h00);
        chk("reset jp_data1", 32'(jp_data1), 32'h1);
        chk("reset jp_data2", 32'(jp_data2), 32'h1);

        btn1_n = 8'hFE;
        repeat (17) tick();
        chk("latency 17 cycles", 32'(pad1_state), 32'h00);
        tick();
        chk("latency 18 cycles", 32'(pad1_state), 32'h01);

        btn1_n = 8'hFC;
        repeat (10) tick();
        btn1_n = 8'hFE;
        chk("glitch during", 32'(pad1_state), 32'h01);
        repeat (30) tick();
        chk("glitch after", 32'(pad1_state), 32'h01);

        for (int v = 0; v < 5; v++) begin
            btn1_n = vecs[v].b1_n;
            btn2_n = vecs[v].b2_n;
            repeat (20) tick();
            chk($sformatf("vec%0d pad1_state", v), 32'(pad1_state), 32'(vecs[v].exp1));
            chk($sformatf("vec%0d pad2_state", v), 32'(pad2_state), 32'(vecs[v].exp2));
            read_frame(vecs[v].exp1, vecs[v].exp2, 10, 4);
        end

        btn1_n = 8'hF6; btn2_n = 8'hFF;
        repeat (20) tick();
        read_frame(8'h09, 8'h00, 9, 64);

        btn2_n = 8'h7F;
        repeat (20) tick();
        jp_clk = 1'b0;
        tick();
        jp_latch = 1'b1; jp_clk = 1'b1;
        tick();
        chk("coincident load data2", 32'(jp_data2), 32'h1);
        jp_latch = 1'b0;
        tick();
        chk("held clk no shift", 32'(jp_data2), 32'h1);
        for (int i = 1; i <= 6; i++) begin
            shift_edge();
            chk($sformatf("coincident shift%0d", i), 32'(jp_data2), 32'h1);
        end
        shift_edge();
        chk("coincident shift7 Right", 32'(jp_data2), 32'h0);
        shift_edge();
        chk("coincident shift8 released", 32'(jp_data2), 32'h1);

        jp_clk = 1'b0; jp_latch = 1'b1;
        tick();
        jp_latch = 1'b0;
        chk("old latch bit0", 32'(jp_data1), 32'h0);
        btn1_n = 8'h5A;
        repeat (20) tick();
        chk("new state debounced", 32'(pad1_state), 32'hA5);
        shift_edge();
        chk("old latch bit1", 32'(jp_data1), 32'h1);
        shift_edge();
        chk("old latch bit2", 32'(jp_data1), 32'h1);
        shift_edge();
        chk("old latch bit3", 32'(jp_data1), 32'h0);

        btn2_n = 8'hC3;
        repeat (20) tick();
        read_frame(8'hA5, 8'h3C, 8, 64);

        jp_clk = 1'b0; jp_latch = 1'b1;
        tick();
        jp_latch = 1'b0;
        repeat (3) shift_edge();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midframe rst pad1", 32'(pad1_state), 32'h00);
        chk("midframe rst pad2", 32'(pad2_state), 32'h00);
        chk("midframe rst data1", 32'(jp_data1), 32'h1);
        chk("midframe rst data2", 32'(jp_data2), 32'h1);
        jp_clk = 1'b0; jp_latch = 1'b1;
        tick();
        jp_latch = 1'b0;
        chk("post rst latch data1", 32'(jp_data1), 32'h1);
        chk("post rst latch data2", 32'(jp_data2), 32'h1);
        repeat (20) tick();
        chk("post rst redebounce", 32'(pad1_state), 32'hA5);

        btn1_n = 8'hFF; btn2_n = 8'hFF; turbo1_n = 2'b10;
        repeat (20) tick();
`ifdef JP_TURBO_EN
        begin : turbo_blk
            logic prevb;
            int   run;
            int   flips;
            bit   started;
            prevb = pad1_state[0]; run = 0; flips = 0; started = 1'b0;
            for (int c = 0; c < 48; c++) begin
                tick();
                run++;
                if (pad1_state[0] !== prevb) begin
                    if (started) chk("turbo half-period", 32'(run), 32'd8);
                    started = 1'b1;
                    run     = 0;
                    flips++;
                    prevb   = pad1_state[0];
                end
            end
            chk("turbo toggles", 32'(flips >= 5), 32'h1);
        end
`else
        for (int c = 0; c < 48; c++) begin
            tick();
            chk("no turbo A", 32'(pad1_state[0]), 32'h0);
        end
        read_frame(8'h00, 8'h00, 1, 1);
`endif
        turbo1_n = 2'b11;

        for (int c = 0; c < 3000; c++) begin
            int k;
            if ($urandom_range(0, 29) == 0) begin
                btn1_n   = 8'($urandom);
                btn2_n   = 8'($urandom);
                turbo1_n = 2'($urandom);
                turbo2_n = 2'($urandom);
            end else if ($urandom_range(0, 19) == 0) begin
                k = int'($urandom_range(0, 7));
                btn1_n[k] = ~btn1_n[k];
            end
            jp_latch = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 2) == 0) jp_clk = ~jp_clk;
            rst = ($urandom_range(0, 999) == 0);
            tick();
            chk("rand pad1_state", 32'(pad1_state), 32'(m_pad(0)));
            chk("rand pad2_state", 32'(pad2_state), 32'(m_pad(1)));
            chk("rand jp_data1", 32'(jp_data1), 32'(m_data(m_ld1, m_idx1)));
            chk("rand jp_data2", 32'(jp_data2), 32'(m_data(m_ld2, m_idx2)));
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jp_pad_emu.md
Name: jp_pad_emu

Overview:
- Emulates two NES standard controllers (CD4021-style 8-bit parallel-in/serial-out shift registers) from raw board switches.
- Sits directly upstream of the joypad controller block: consumes its jp_latch/jp_clk strobes and drives its jp_data1/jp_data2 serial inputs.
- Per-button 2-FF synchroniser plus counter debounce; active-low serial output, bit order A, B, Select, Start, Up, Down, Left, Right.

Parameters:
- DEBOUNCE_W, 16: width of each per-button debounce counter; a level change is accepted after 2^DEBOUNCE_W-1 consecutive stable cycles.
- TURBO_DIV_W, 20: turbo oscillator divider width (used only with JP_TURBO_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- btn1_n  in  8  pad 1 raw switches, active-low, asynchronous; [0]=A [1]=B [2]=Select [3]=Start [4]=Up [5]=Down [6]=Left [7]=Right
- btn2_n  in  8  pad 2 raw switches, same encoding
- turbo1_n  in  2  pad 1 turbo A [0] / turbo B [1], active-low, asynchronous
- turbo2_n  in  2  pad 2 turbo switches
- jp_clk  in  1  serial shift clock from joypad controller (same clk domain, registered)
- jp_latch  in  1  parallel-load strobe from joypad controller (same clk domain, registered)
- jp_data1  out  1  pad 1 serial data, active-low (0 = pressed)
- jp_data2  out  1  pad 2 serial data, active-low
- pad1_state  out  8  debounced pad 1 buttons, active-high (debug/LED)
- pad2_state  out  8  debounced pad 2 buttons, active-high

Behaviour:
- Reset: sync flops = 1 (released); debounce counters = 0; pad1_state/pad2_state = 8'h00; shift regs = 8'hFF; jp_data1/jp_data2 = 1; jp_clk edge-detect flop = 0; turbo divider = 0.
- Synchroniser: 2 flops per switch; debounce operates on the second stage.
- Debounce, per button: if synced_pressed == stable, counter <= 0; else counter += 1; when counter == all-ones and still differing, stable <= synced_pressed, counter <= 0. Glitch shorter than 2^DEBOUNCE_W-1 cycles: no change. Pipeline latency from switch to stable = 2 + (2^DEBOUNCE_W-1) + 1 cycles.
- Shift register per pad, priority order:
  - jp_latch == 1: sr <= ~pad_state every cycle (transparent parallel load, live buttons).
  - else on jp_clk rising edge (jp_clk == 1 && prev_jp_clk == 0): sr <= {1'b1, sr[7:1]}.
  - else hold.
- jp_data = sr[0] (registered; valid 1 cycle after load/shift edge).
- Latch high coincident with a jp_clk rising edge: load wins, shift discarded.
- More than 8 shifts without latch: output 1 (released) indefinitely.
- jp_clk held high: one shift only (edge-triggered).
- Button change while latch low: not visible until next latch.
- rst mid-frame: shift regs return to 8'hFF, debounced state cleared; the next latch loads the fresh state.

Optional Feature:
- Macro JP_TURBO_EN.
- Defined: free-running TURBO_DIV_W-bit counter; turbo_phase = counter MSB. Debounced turbo A/B (same debounce path) are ORed into A/B as (turbo & turbo_phase) before the parallel load. pad*_state reflects the ORed value.
- Undefined: turbo inputs ignored (no synchroniser or logic generated); A/B come from btn*_n only.

Test Plan:
- Reset with all switches released, DEBOUNCE_W=4 -> pad1_state=pad2_state=8'h00, jp_data1=jp_data2=1.
- btn1_n=8'hFE held 20 cycles -> pad1_state=8'h01 after exactly 2+15+1 cycles; a 10-cycle 0 pulse on btn1_n[1] -> pad1_state unchanged.
- pad1_state=8'h09 (A+Start), latch 1 cycle, then 8 jp_clk rising edges 64 cycles apart -> jp_data1 sequence 0,1,1,0,1,1,1,1; 9th edge -> 1.
- jp_latch=1 with jp_clk rising in the same cycle, pad2_state=8'h80 -> sr2=8'h7F, jp_data2=1, no shift.
- Drive the full joypad-controller frame (latch at cnt 0, clocks every 64) with pad1=8'hA5 and pad2=8'h3C -> controller state registers read 8'hA5 and 8'h3C.
- JP_TURBO_EN, TURBO_DIV_W=4, turbo1_n[0]=0 held -> A bit loaded as pressed for 8-cycle half-periods and released for alternating 8-cycle half-periods; without the macro -> A never pressed.
